// File: rtl/significand_unpack_pipe.sv
// significand_unpack_pipe: valid/ready pipelined half/single/double significand unpacker.
// Define SIG_NORM_EN to build the leading-zero counter and normalising shifter.
module significand_unpack_pipe #(
    parameter int N    = 64,
    parameter bit PIPE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [1:0]   fmt_i,
    input  logic [N-1:0] x_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [52:0]  f_o,
    output logic         fz_o,
    output logic         ez_o,
    output logic [2:0]   cls_o,
    output logic [5:0]   lz_o,
    output logic [52:0]  fn_o,
    output logic         err_o
);
    logic        is_h, is_s, ez_c, ei_c, fz_c, unused_sign;
    logic [51:0] frac_c;
    logic        s1_valid_q, s1_valid_d, s2_can_load, in_fire;
    logic [52:0] f1_q;
    logic        fz1_q, ez1_q, err1_q;
    logic [2:0]  cls1_q;
    logic [5:0]  lz_c;
    logic [52:0] fn_c;

    assign unused_sign = x_i[N-1];
    // fmt 11 falls through to the double field map; err flags it downstream
    assign is_h   = fmt_i == 2'b10;
    assign is_s   = fmt_i == 2'b00;
    assign frac_c = is_h ? {x_i[57:48], 42'd0} : is_s ? {x_i[54:32], 29'd0} : x_i[51:0];
    assign ez_c   = is_h ? ~|x_i[62:58] : is_s ? ~|x_i[62:55] : ~|x_i[62:52];
    assign ei_c   = is_h ? &x_i[62:58] : is_s ? &x_i[62:55] : &x_i[62:52];
    assign fz_c   = ~|frac_c;

    assign in_ready_o = ~s1_valid_q | s2_can_load;
    assign in_fire    = in_valid_i & in_ready_o;
    assign s1_valid_d = in_fire | (s1_valid_q & ~s2_can_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            f1_q       <= '0;
            fz1_q      <= 1'b0;
            ez1_q      <= 1'b0;
            cls1_q     <= '0;
            err1_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                f1_q   <= {~ez_c, frac_c};
                fz1_q  <= fz_c;
                ez1_q  <= ez_c;
                cls1_q <= {ei_c & ~fz_c, ei_c & fz_c, ez_c & fz_c};
                err1_q <= &fmt_i;
            end
        end
    end

`ifdef SIG_NORM_EN
    // highest set bit wins; an all-zero significand keeps the default of 53
    always_comb begin
        lz_c = 6'd53;
        for (int i = 0; i < 53; i++)
            if (f1_q[i]) lz_c = 6'(52 - i);
    end
    assign fn_c = f1_q << lz_c;
`else
    assign lz_c = '0;
    assign fn_c = f1_q;
`endif

    if (PIPE) begin : g_pipe
        logic        s2_valid_q, s2_valid_d, s2_load;
        logic [52:0] f2_q, fn2_q;
        logic        fz2_q, ez2_q, err2_q;
        logic [2:0]  cls2_q;
        logic [5:0]  lz2_q;

        assign s2_can_load = ~s2_valid_q | out_ready_i;
        assign s2_load     = s1_valid_q & s2_can_load;
        assign s2_valid_d  = s2_load | (s2_valid_q & ~out_ready_i);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                f2_q       <= '0;
                fn2_q      <= '0;
                lz2_q      <= '0;
                fz2_q      <= 1'b0;
                ez2_q      <= 1'b0;
                cls2_q     <= '0;
                err2_q     <= 1'b0;
            end else begin
                s2_valid_q <= s2_valid_d;
                if (s2_load) begin
                    f2_q   <= f1_q;
                    fn2_q  <= fn_c;
                    lz2_q  <= lz_c;
                    fz2_q  <= fz1_q;
                    ez2_q  <= ez1_q;
                    cls2_q <= cls1_q;
                    err2_q <= err1_q;
                end
            end
        end

        assign out_valid_o = s2_valid_q;
        assign f_o         = f2_q;
        assign fn_o        = fn2_q;
        assign lz_o        = lz2_q;
        assign fz_o        = fz2_q;
        assign ez_o        = ez2_q;
        assign cls_o       = cls2_q;
        assign err_o       = err2_q;
    end else begin : g_comb
        assign s2_can_load = out_ready_i;
        assign out_valid_o = s1_valid_q;
        assign f_o         = f1_q;
        assign fn_o        = fn_c;
        // masked so an empty stage reads lz = 0 rather than 53
        assign lz_o        = s1_valid_q ? lz_c : '0;
        assign fz_o        = fz1_q;
        assign ez_o        = ez1_q;
        assign cls_o       = cls1_q;
        assign err_o       = err1_q;
    end
endmodule
